// File: rtl/io_intr_ctrl_pkg.sv
// Shared definitions for the I/O interrupt controller: datapath width and the
// delivery FSM state encoding.
package io_intr_ctrl_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StGap     = 2'd2
  } state_e;

endpackage

// File: rtl/io_fifo.sv
// Parameterised synchronous FIFO with registered storage, synchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/io_intr_ctrl.sv
// Peripheral-side I/O controller for the 16-bit MIPS core: queues host words and
// delivers them by interrupt, and captures core output words for the host.
// Optional feature macro INT_STATS_EN enables the irq_count delivery counter;
// without it irq_count is tied to 0.
module io_intr_ctrl
  import io_intr_ctrl_pkg::*;
#(
  parameter int unsigned DW      = io_intr_ctrl_pkg::DW,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] host_in_data,
  input  logic          host_in_valid,
  output logic          host_in_ready,
  output logic [DW-1:0] cpu_data_in,
  output logic          cpu_interrupt,
  input  logic          cpu_ack,
  input  logic [DW-1:0] cpu_data_out,
  input  logic          cpu_out_we,
  output logic [DW-1:0] host_out_data,
  output logic          host_out_valid,
  input  logic          host_out_ready,
  output logic          overrun,
  output logic          timeout_flag,
  output logic [15:0]   irq_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GapMax   = GW'(GAP - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          fifo_pop;
  logic          timeout_hit;

  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;

  logic [DW-1:0] data_in_q;
  logic          timeout_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          overrun_q;
  logic          out_load;

  assign host_in_ready = !fifo_full;
  assign fifo_push     = host_in_valid && host_in_ready;

  io_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fifo_push),
    .wr_data(host_in_data),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Delivery FSM state, timer and gap counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic; an ack on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    fifo_pop    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_count != '0) begin
          state_d = StPresent;
          timer_d = '0;
        end
      end
      StPresent: begin
        if (cpu_ack) begin
          fifo_pop = 1'b1;
          timer_d  = '0;
          gap_d    = '0;
          state_d  = StGap;
        end else if (timer_q == TimerMax) begin
          timeout_hit = 1'b1;
          timer_d     = '0;
          gap_d       = '0;
          state_d     = StGap;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapMax) begin
          state_d = (fifo_count != '0) ? StPresent : StIdle;
          timer_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_interrupt = (state_q == StPresent);

  // Registered copy of the FIFO head presented to the core; zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_in_q <= '0;
    end else begin
      data_in_q <= fifo_empty ? '0 : fifo_head;
    end
  end

  assign cpu_data_in = data_in_q;

  // Sticky timeout indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_flag = timeout_q;

  // A core write is accepted when the slot is free or being drained this cycle.
  assign out_load = cpu_out_we && (!out_valid_q || host_out_ready);

  // One-deep output register with sticky overrun on a dropped write.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (out_load) begin
        out_data_q  <= cpu_data_out;
        out_valid_q <= 1'b1;
      end else if (host_out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (cpu_out_we && !out_load) overrun_q <= 1'b1;
    end
  end

  assign host_out_data  = out_data_q;
  assign host_out_valid = out_valid_q;
  assign overrun        = overrun_q;

`ifdef INT_STATS_EN
  logic [15:0] irq_count_q;

  // Count acknowledged deliveries; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_count_q <= '0;
    end else if (fifo_pop) begin
      irq_count_q <= irq_count_q + 16'd1;
    end
  end

  assign irq_count = irq_count_q;
`else
  assign irq_count = '0;
`endif

endmodule
